// File: rtl/sram_ctrl_pkg.sv
// Shared types and default widths for the data-SRAM request controller.
package sram_ctrl_pkg;

    localparam int SRAM_CTRL_DEF_N     = 8;
    localparam int SRAM_CTRL_DEF_CNT_W = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_ISSUE,
        ST_RD_WAIT,
        ST_WR_ISSUE,
        ST_RESP
    } sram_ctrl_state_t;

endpackage

// File: rtl/sram_ctrl_sat_counter.sv
// Saturating event counter used for the load/store statistics.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (inc && (r_count != '1)) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign count = r_count;

endmodule

// File: rtl/sram_ctrl.sv
// Single-outstanding load/store controller in front of a registered-read SRAM.
// Optional statistics counters are enabled by defining SRAM_CTRL_STATS_EN.
module sram_ctrl
    import sram_ctrl_pkg::*;
#(
    parameter int N = SRAM_CTRL_DEF_N
`ifdef SRAM_CTRL_STATS_EN
    ,
    parameter int CNT_W = SRAM_CTRL_DEF_CNT_W
`endif
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_write,
    input  logic [N-1:0]     req_addr,
    input  logic [N-1:0]     req_wdata,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [N-1:0]     resp_rdata,
    output logic             SRAM_readEnable,
    output logic             SRAM_writeEnable,
    output logic [N-1:0]     SRAM_address,
    output logic [N-1:0]     SRAM_data_in,
    input  logic [N-1:0]     SRAM_data
`ifdef SRAM_CTRL_STATS_EN
    ,
    output logic [CNT_W-1:0] load_count,
    output logic [CNT_W-1:0] store_count
`endif
);

    sram_ctrl_state_t r_state;
    logic [N-1:0]     r_addr;
    logic [N-1:0]     r_wdata;
    logic [N-1:0]     r_rdata;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (req_valid) begin
                        r_addr  <= req_addr;
                        r_wdata <= req_wdata;
                        r_state <= req_write ? ST_WR_ISSUE : ST_RD_ISSUE;
                    end
                end
                ST_RD_ISSUE: r_state <= ST_RD_WAIT;
                ST_RD_WAIT: begin
                    r_rdata <= SRAM_data;
                    r_state <= ST_RESP;
                end
                ST_WR_ISSUE: begin
                    r_rdata <= '0;
                    r_state <= ST_RESP;
                end
                ST_RESP: begin
                    if (resp_ready) r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Every handshake/enable is a pure decode of the state register.
    assign req_ready        = (r_state == ST_IDLE);
    assign resp_valid       = (r_state == ST_RESP);
    assign resp_rdata       = r_rdata;
    assign SRAM_readEnable  = (r_state == ST_RD_ISSUE);
    assign SRAM_writeEnable = (r_state == ST_WR_ISSUE);
    assign SRAM_address     = r_addr;
    assign SRAM_data_in     = r_wdata;

`ifdef SRAM_CTRL_STATS_EN
    logic r_write;
    logic w_resp_hs;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_write <= 1'b0;
        end else if (req_valid && (r_state == ST_IDLE)) begin
            r_write <= req_write;
        end
    end

    assign w_resp_hs = resp_valid && resp_ready;

    sat_counter #(.CNT_W(CNT_W)) u_load_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (w_resp_hs && !r_write),
        .count (load_count)
    );

    sat_counter #(.CNT_W(CNT_W)) u_store_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (w_resp_hs && r_write),
        .count (store_count)
    );
`endif

endmodule
